instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port stall  input  1  hold current instr; no new fetch.
REQ-004 SHALL have port pc_immd_sel  input  1  redirect to pc_immd (B/JAL).
REQ-005 SHALL have port pc_immd  input  22  immediate target.
REQ-006 SHALL have port pc_reg_sel  input  1  redirect to pc_reg_data[21:0] (JR).
REQ-007 SHALL have port pc_reg_data  input  32  register target; bits [31:22] ignored.
REQ-008 SHALL have port hlt  input  1  decoded HALT.
REQ-009 SHALL have ports imem_req (output, 1) and imem_addr (output, 22): fetch request and word address.
REQ-010 SHALL have ports imem_rdy (input, 1) and imem_rdata (input, 32): same-cycle fetch accept and data.
REQ-011 SHALL have ports instr (output, 32) and instr_valid (output, 1): registered instruction to decode.
REQ-012 SHALL have port pc_link  output  32  zero-extended (address of instr)+1, for JAL writeback.
REQ-013 SHALL have port halted  output  1  fetch stopped.

Function
REQ-014 SHALL implement states FETCH, HALTED, plus RESUME only when IF_HALT_RESUME_EN is defined.
REQ-015 In FETCH with stall=0, SHALL drive imem_req=1 and imem_addr=pc.
REQ-016 Fetch completes when imem_req=1 and imem_rdy=1; at that edge instr<=imem_rdata, instr_valid<=1, instr_pc<=pc, pc<=pc+1.
REQ-017 While imem_rdy=0, SHALL hold imem_addr stable, keep imem_req=1, and drive instr_valid<=0 at the next edge.
REQ-018 With stall=1, SHALL drive imem_req=0 and hold pc, instr, instr_valid, and pc_link unchanged.
REQ-019 Redirect is qualified only when instr_valid=1 and stall=0; a redirect SHALL discard the same-cycle fetch result, set instr_valid<=0, and set pc<=target.
REQ-020 If pc_reg_sel and pc_immd_sel are both 1, pc_reg_sel SHALL win.
REQ-021 Taken redirect SHALL cost exactly one bubble; the target instruction is valid two edges after the redirect cycle when imem_rdy=1.
REQ-022 hlt=1 with instr_valid=1 and stall=0 SHALL move to HALTED: imem_req=0, instr_valid<=0, halted=1; hlt SHALL beat any redirect.
REQ-023 pc SHALL wrap from 22'h3FFFFF to 0 with no flag.
REQ-024 pc_link SHALL equal {10'b0, instr_pc+1}, wrapping identically.
REQ-025 In HALTED, SHALL ignore stall, redirects, and imem_rdy, and drive imem_req=0.

Reset
REQ-026 While rst=0, SHALL hold pc=0, instr=0, instr_valid=0, pc_link=1, imem_req=0, halted=0, state=FETCH.
REQ-027 Deassertion SHALL start a fetch of address 0 on the first edge after release.
REQ-028 Reset assertion mid-fetch or mid-halt SHALL abort immediately; no imem_rdata is captured.

Configuration
REQ-029 Macro IF_HALT_RESUME_EN SHALL gate a 1-bit input resume.
REQ-030 With IF_HALT_RESUME_EN defined: resume=1 in HALTED SHALL move to FETCH at pc = halt instr address+1, with halted<=0.
REQ-031 Without IF_HALT_RESUME_EN: the resume port SHALL be absent, and HALTED SHALL be left only by reset.

Verification
REQ-032 Reset release, imem_rdy=1, rdata=addr -> instr 0,1,2 valid on edges 1,2,3; pc_link 1,2,3.
REQ-033 imem_rdy=0 for 3 cycles at addr 5 -> imem_addr=5 held; instr_valid=0 for 3 cycles; then instr for addr 5.
REQ-034 stall=1 for 2 cycles at instr addr 7 -> imem_req=0, instr and pc_link=8 unchanged; fetch resumes at 8.
REQ-035 pc_immd_sel=1 with pc_immd=0x100 and pc_reg_sel=1 with pc_reg_data=0xFFC00040 -> one bubble, then instr from 0x040.
REQ-036 pc=0x3FFFFF fetched -> next imem_addr=0, pc_link=0; hlt at addr 9 -> halted=1, imem_req=0; resume (if enabled) -> fetch addr 10.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Instruction-memory fetch bus shared by instr_fetch (master) and the memory (slave).
// The memory answers a request in the same cycle with imem_rdy and imem_rdata.
interface instr_fetch_if;
    logic        imem_req;
    logic [21:0] imem_addr;
    logic        imem_rdy;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdy,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdy,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// Single-issue instruction fetch stage with stall, branch/jump redirect and HALT handling.
// Define IF_HALT_RESUME_EN to add the resume input and the RESUME state that leaves HALTED.
module instr_fetch (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 pc_immd_sel,
    input  logic [21:0]          pc_immd,
    input  logic                 pc_reg_sel,
    input  logic [31:0]          pc_reg_data,
    input  logic                 hlt,
`ifdef IF_HALT_RESUME_EN
    input  logic                 resume,
`endif
    instr_fetch_if.master        imem,
    output logic [31:0]          instr,
    output logic                 instr_valid,
    output logic [31:0]          pc_link,
    output logic                 halted
);

`ifdef IF_HALT_RESUME_EN
    typedef enum logic [1:0] {FETCH, HALTED, RESUME} state_t;
`else
    typedef enum logic [0:0] {FETCH, HALTED} state_t;
`endif

    state_t      state;
    logic [21:0] pc;
    logic [21:0] instr_pc;
    logic        take_hlt;
    logic        take_redirect;
    logic [21:0] redirect_target;
    logic        unused_reg_hi;

    // Control flow decisions only act on a live instruction in decode.
    assign take_hlt        = instr_valid && !stall && hlt;
    assign take_redirect   = instr_valid && !stall && (pc_reg_sel || pc_immd_sel);
    assign redirect_target = pc_reg_sel ? pc_reg_data[21:0] : pc_immd;
    assign unused_reg_hi   = ^pc_reg_data[31:22];

    assign imem.imem_req  = rst && (state == FETCH) && !stall;
    assign imem.imem_addr = pc;
    assign pc_link        = {10'b0, instr_pc + 22'd1};

    // Halt outranks redirect, and any redirect throws away the fetch landing this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            pc          <= 22'd0;
            instr_pc    <= 22'd0;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!stall) begin
                        if (take_hlt) begin
                            state       <= HALTED;
                            halted      <= 1'b1;
                            instr_valid <= 1'b0;
                            pc          <= instr_pc + 22'd1;
                        end else if (take_redirect) begin
                            pc          <= redirect_target;
                            instr_valid <= 1'b0;
                        end else if (imem.imem_rdy) begin
                            instr       <= imem.imem_rdata;
                            instr_valid <= 1'b1;
                            instr_pc    <= pc;
                            pc          <= pc + 22'd1;
                        end else begin
                            instr_valid <= 1'b0;
                        end
                    end
                end
                HALTED: begin
                    instr_valid <= 1'b0;
`ifdef IF_HALT_RESUME_EN
                    if (resume) begin
                        state  <= RESUME;
                        halted <= 1'b0;
                    end
`endif
                end
`ifdef IF_HALT_RESUME_EN
                // One quiet cycle so decode sees halted drop before fetching restarts.
                RESUME: begin
                    state <= FETCH;
                end
`endif
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; memory returns {10'b0, address} as data.
// Covers reset, streaming, wait states, stall, redirect priority, wrap, halt and async reset.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        pc_immd_sel;
    logic [21:0] pc_immd;
    logic        pc_reg_sel;
    logic [31:0] pc_reg_data;
    logic        hlt;
    logic        rdy;
    logic        resume;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc_link;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    instr_fetch_if bus ();

    assign bus.imem_rdy   = rdy;
    assign bus.imem_rdata = {10'b0, bus.imem_addr};

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .pc_immd_sel (pc_immd_sel),
        .pc_immd     (pc_immd),
        .pc_reg_sel  (pc_reg_sel),
        .pc_reg_data (pc_reg_data),
        .hlt         (hlt),
`ifdef IF_HALT_RESUME_EN
        .resume      (resume),
`endif
        .imem        (bus.master),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc_link     (pc_link),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic s, input logic is, input logic [21:0] im,
                                 input logic rs, input logic [31:0] rd, input logic h, input logic r);
        stall       = s;
        pc_immd_sel = is;
        pc_immd     = im;
        pc_reg_sel  = rs;
        pc_reg_data = rd;
        hlt         = h;
        rdy         = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkFetchState(input string tag, input logic [31:0] exp_instr, input logic exp_valid,
                                   input logic [31:0] exp_link, input logic [21:0] exp_addr);
        checkOutput({tag, ".instr"}, instr, exp_instr);
        checkOutput({tag, ".valid"}, {31'b0, instr_valid}, {31'b0, exp_valid});
        checkOutput({tag, ".link"}, pc_link, exp_link);
        checkOutput({tag, ".addr"}, {10'b0, bus.imem_addr}, {10'b0, exp_addr});
    endtask

    initial begin
        rst    = 1'b0;
        resume = 1'b0;
        applyStimulus(1'b0, 1'b0, 22'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 22'd0, 1'b0, 32'd0, 1'b0, 1'b1);

        checkFetchState("reset", 32'd0, 1'b0, 32'd1, 22'd0);
        checkOutput("reset.req", {31'b0, bus.imem_req}, 32'd0);
        checkOutput("reset.halted", {31'b0, halted}, 32'd0);

        rst = 1'b1;
        #1;
        checkOutput("release.req", {31'b0, bus.imem_req}, 32'd1);
        checkOutput("release.addr", {10'b0, bus.imem_addr}, 32'd0);

        // Back-to-back fetches from address 0.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 22'd0, 1'b0, 32'd0, 1'b0, 1'b1);
            checkFetchState($sformatf("stream%0d", i), i, 1'b1, i + 1, 22'(i + 1));
        end

        // Three wait states at address 5.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 22'd0, 1'b0, 32'd0, 1'b0, 1'b0);
            checkOutput($sformatf("wait%0d.valid", i), {31'b0, instr_valid}, 32'd0);
            checkOutput($sformatf("wait%0d.addr", i), {10'b0, bus.imem_addr}, 32'd5);
            checkOutput($sformatf("wait%0d.req", i), {31'b0, bus.imem_req}, 32'd1);
        end
        for (int i = 5; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 22'd0, 1'b0, 32'd0, 1'b0, 1'b1);
            checkFetchState($sformatf("after_wait%0d", i), i, 1'b1, i + 1, 22'(i + 1));
        end

        // Stall two cycles while instr 7 sits in decode.
        for (int i = 0; i < 2; i++) begin
            stall = 1'b1;
            #1;
            checkOutput($sformatf("stall%0d.req", i), {31'b0, bus.imem_req}, 32'd0);
            applyStimulus(1'b1, 1'b0, 22'd0, 1'b0, 32'd0, 1'b0, 1'b1);
            checkFetchState($sformatf("stall%0d", i), 32'd7, 1'b1, 32'd8, 22'd8);
        end
        applyStimulus(1'b0, 1'b0, 22'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        checkFetchState("unstall", 32'd8, 1'b1, 32'd9, 22'd9);

        // Both redirects: the register target wins and upper bits are dropped.
        applyStimulus(1'b0, 1'b1, 22'h100, 1'b1, 32'hFFC0_0040, 1'b0, 1'b1);
        checkFetchState("redir_bubble", 32'd8, 1'b0, 32'd9, 22'h040);
        applyStimulus(1'b0, 1'b0, 22'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        checkFetchState("redir_target", 32'h40, 1'b1, 32'h41, 22'h041);

        // Jump to the top address and wrap.
        applyStimulus(1'b0, 1'b0, 22'd0, 1'b1, 32'h003F_FFFF, 1'b0, 1'b1);
        checkFetchState("wrap_bubble", 32'h40, 1'b0, 32'h41, 22'h3FFFFF);
        applyStimulus(1'b0, 1'b0, 22'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        checkFetchState("wrap_top", 32'h003F_FFFF, 1'b1, 32'd0, 22'd0);

        // Immediate redirect to 9.
        applyStimulus(1'b0, 1'b1, 22'd9, 1'b0, 32'd0, 1'b0, 1'b1);
        checkFetchState("immd_bubble", 32'h003F_FFFF, 1'b0, 32'd0, 22'd9);
        applyStimulus(1'b0, 1'b0, 22'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        checkFetchState("immd_target", 32'd9, 1'b1, 32'd10, 22'd10);

        // A stalled halt must not take effect.
        applyStimulus(1'b1, 1'b0, 22'd0, 1'b0, 32'd0, 1'b1, 1'b1);
        checkOutput("hlt_stalled.halted", {31'b0, halted}, 32'd0);
        checkFetchState("hlt_stalled", 32'd9, 1'b1, 32'd10, 22'd10);

        // Halt beats a simultaneous redirect.
        applyStimulus(1'b0, 1'b1, 22'h123, 1'b0, 32'd0, 1'b1, 1'b1);
        checkOutput("halt.halted", {31'b0, halted}, 32'd1);
        checkOutput("halt.req", {31'b0, bus.imem_req}, 32'd0);
        checkFetchState("halt", 32'd9, 1'b0, 32'd10, 22'd10);

        // Halted ignores stall, redirects and rdy.
        applyStimulus(1'b1, 1'b1, 22'h55, 1'b1, 32'h77, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 22'h55, 1'b1, 32'h77, 1'b0, 1'b1);
        checkOutput("halt_hold.halted", {31'b0, halted}, 32'd1);
        checkOutput("halt_hold.req", {31'b0, bus.imem_req}, 32'd0);
        checkFetchState("halt_hold", 32'd9, 1'b0, 32'd10, 22'd10);

        // Asynchronous reset out of HALTED, between clock edges.
        applyStimulus(1'b0, 1'b0, 22'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst.halted", {31'b0, halted}, 32'd0);
        checkOutput("async_rst.req", {31'b0, bus.imem_req}, 32'd0);
        checkFetchState("async_rst", 32'd0, 1'b0, 32'd1, 22'd0);
        applyStimulus(1'b0, 1'b0, 22'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        checkFetchState("in_rst", 32'd0, 1'b0, 32'd1, 22'd0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 22'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        checkFetchState("rerelease", 32'd0, 1'b1, 32'd1, 22'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
